// File: rtl/pipe_rca_pkg.sv
// rtl/pipe_rca_pkg.sv - shared constants, stage record and helpers for pipe_rca
//
// Purpose: default geometry of the pipelined ripple-carry adder, the per-stage
//          control record, and the signed-overflow helper used when
//          PIPE_RCA_OVF_EN is defined.
// Ports:   none (package).
package pipe_rca_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  // Control part of a stage record. The partial sum and the remaining operand
  // bits shrink/grow per stage, so they sit next to this record in each stage.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

`ifdef PIPE_RCA_OVF_EN
  // Two's-complement overflow: operands share a sign and the result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction
`endif

endpackage

// File: rtl/pipe_rca_if.sv
// rtl/pipe_rca_if.sv - operand/result handshake bundle for pipe_rca
//
// Purpose: groups the input (operand) and output (result) handshakes.
// Ports:   in_valid/in_ready/a/b/cin  operand channel (master -> slave)
//          out_valid/out_ready/sum/cout  result channel (slave -> master)
//          ovf  signed overflow, present only with PIPE_RCA_OVF_EN
// Modports: master = producer/consumer side, slave = adder side.
interface pipe_rca_if #(
  parameter int WIDTH = pipe_rca_pkg::DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPE_RCA_OVF_EN
  logic             ovf;

  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/rca_chunk.sv
// rtl/rca_chunk.sv - combinational CHUNK-bit ripple-carry adder
//
// Purpose: one pipeline stage's worth of addition.
// Ports:   a, b  CHUNK-bit addends
//          cin   carry in
//          s     CHUNK-bit sum
//          co    carry out
module rca_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  always_comb begin
    logic c;
    s = '0;
    c = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/pipe_rca.sv
// rtl/pipe_rca.sv - pipelined ripple-carry adder, CHUNK bits per stage
//
// Purpose: computes {cout, sum} = a + b + cin over NSTG = WIDTH/CHUNK stages
//          with a valid/ready handshake on both ends; bubbles collapse.
// Ports:   clk  rising-edge clock
//          rst  asynchronous active-high reset
//          bus  pipe_rca_if.slave (operand in, result out)
// Config:  PIPE_RCA_OVF_EN adds bus.ovf, the signed overflow held with sum.
module pipe_rca
  import pipe_rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic           clk,
  input  logic           rst,
  pipe_rca_if.slave      bus
);

  localparam int NSTG = (CHUNK >= 1) ? WIDTH / CHUNK : 1;

  if (CHUNK < 1) begin : g_bad_chunk
    $error("pipe_rca: CHUNK must be at least 1");
  end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("pipe_rca: WIDTH must be a multiple of CHUNK");
  end

  logic [NSTG-1:0] vld;
  logic [NSTG-1:0] rdy;

`ifdef PIPE_RCA_OVF_EN
  logic ovf_q;
`endif

  // Stage k may load when any stage at or after it is empty or the consumer
  // takes the result; this is the purely combinational ready chain.
  always_comb begin
    rdy = '0;
    for (int k = 0; k < NSTG; k++) begin
      rdy[k] = bus.out_ready;
      for (int j = k; j < NSTG; j++) begin
        if (!vld[j]) rdy[k] = 1'b1;
      end
    end
  end

  assign bus.in_ready = rdy[0];

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    // IW: operand bits still to be added on entry; SW: sum bits produced so far.
    localparam int IW = WIDTH - k * CHUNK;
    localparam int SW = (k + 1) * CHUNK;

    logic [IW-1:0]    a_in;
    logic [IW-1:0]    b_in;
    logic             c_in;
    logic             v_in;
    logic [CHUNK-1:0] s;
    logic             co;
    logic [SW-1:0]    sum_nx;
    stage_ctl_t       ctl_q;
    logic [SW-1:0]    sum_q;

    if (k == 0) begin : g_src
      assign a_in   = bus.a;
      assign b_in   = bus.b;
      assign c_in   = bus.cin;
      assign v_in   = bus.in_valid;
      assign sum_nx = s;
    end else begin : g_src
      assign a_in   = g_stg[k-1].g_rem.a_rem;
      assign b_in   = g_stg[k-1].g_rem.b_rem;
      assign c_in   = g_stg[k-1].ctl_q.carry;
      assign v_in   = g_stg[k-1].ctl_q.valid;
      assign sum_nx = {s, g_stg[k-1].sum_q};
    end

    rca_chunk #(.CHUNK(CHUNK)) u_add (
      .a   (a_in[CHUNK-1:0]),
      .b   (b_in[CHUNK-1:0]),
      .cin (c_in),
      .s   (s),
      .co  (co)
    );

    // Data only moves with a valid operation, so a stalled result is untouched.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctl_q <= '0;
        sum_q <= '0;
      end else if (rdy[k]) begin
        ctl_q.valid <= v_in;
        if (v_in) begin
          ctl_q.carry <= co;
          sum_q       <= sum_nx;
        end
      end
    end

    if (IW > CHUNK) begin : g_rem
      logic [IW-CHUNK-1:0] a_rem;
      logic [IW-CHUNK-1:0] b_rem;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_rem <= '0;
          b_rem <= '0;
        end else if (rdy[k] && v_in) begin
          a_rem <= a_in[IW-1:CHUNK];
          b_rem <= b_in[IW-1:CHUNK];
        end
      end
    end

`ifdef PIPE_RCA_OVF_EN
    // The last stage sees the operand sign bits and produces the result sign.
    if (k == NSTG - 1) begin : g_ovf
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (rdy[k] && v_in) begin
          ovf_q <= add_ovf(a_in[CHUNK-1], b_in[CHUNK-1], s[CHUNK-1]);
        end
      end
    end
`endif

    assign vld[k] = ctl_q.valid;
  end

  assign bus.out_valid = g_stg[NSTG-1].ctl_q.valid;
  assign bus.sum       = g_stg[NSTG-1].sum_q;
  assign bus.cout      = g_stg[NSTG-1].ctl_q.carry;
`ifdef PIPE_RCA_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_rca.sv
// tb/tb_pipe_rca.sv - directed self-checking bench for pipe_rca
module tb_pipe_rca;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_rca_if #(.WIDTH(32)) bus32 ();
  pipe_rca_if #(.WIDTH(16)) bus16 ();

  pipe_rca #(.WIDTH(32), .CHUNK(8)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  pipe_rca #(.WIDTH(16), .CHUNK(4)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

  int total  = 0;
  int passed = 0;

  logic [31:0] obs_sum;
  logic        obs_cout;
`ifdef PIPE_RCA_OVF_EN
  logic        obs_ovf;
`endif

  logic [31:0] a_t [10];
  logic [31:0] b_t [10];
  logic        c_t [10];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic run_one32(input logic [31:0] a, input logic [31:0] b, input logic c,
                           input string tag);
    int lat;
    @(negedge clk);
    bus32.a = a; bus32.b = b; bus32.cin = c;
    bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, 64'(bus32.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus32.in_valid = 1'b0;
    bus32.a = 32'hDEADBEEF; bus32.b = 32'h0BADF00D; bus32.cin = ~c;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus32.out_valid && lat < 20);
    check({tag, "_latency"}, 64'(lat), 64'd4);
    obs_sum  = bus32.sum;
    obs_cout = bus32.cout;
`ifdef PIPE_RCA_OVF_EN
    obs_ovf  = bus32.ovf;
`endif
  endtask

  task automatic run_one16(input logic [15:0] a, input logic [15:0] b, input logic c,
                           input string tag);
    int lat;
    @(negedge clk);
    bus16.a = a; bus16.b = b; bus16.cin = c;
    bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
    @(posedge clk);
    #1 bus16.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus16.out_valid && lat < 20);
    check({tag, "_latency"}, 64'(lat), 64'd4);
    obs_sum  = {16'h0, bus16.sum};
    obs_cout = bus16.cout;
  endtask

  initial begin
    int          sent, recv, fell_at, saw_valid, lat;
    logic        acc, xfer, held_valid;
    logic [31:0] held_sum;
    logic [32:0] e;

    a_t = '{32'h00000001, 32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'h0000FFFF,
            32'hA5A5A5A5, 32'h7FFFFFFF, 32'h00FF00FF, 32'hDEADBEEF, 32'h00000000};
    b_t = '{32'h00000002, 32'h00000001, 32'h87654321, 32'h80000000, 32'h00000001,
            32'h5A5A5A5A, 32'h7FFFFFFF, 32'hFF00FF01, 32'h21524110, 32'h00000000};
    c_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
    check("rst_sum",       64'(bus32.sum),       64'd0);
    check("rst_cout",      64'(bus32.cout),      64'd0);
`ifdef PIPE_RCA_OVF_EN
    check("rst_ovf",       64'(bus32.ovf),       64'd0);
`endif
    rst = 1'b0;
    #1 check("rst_in_ready", 64'(bus32.in_ready), 64'd1);

    run_one32(32'h00000000, 32'h00000000, 1'b0, "zero");
    check("zero_sum",  64'(obs_sum),  64'h0);
    check("zero_cout", 64'(obs_cout), 64'd0);

    run_one32(32'hFFFFFFFF, 32'h00000001, 1'b0, "wrap");
    check("wrap_sum",  64'(obs_sum),  64'h0);
    check("wrap_cout", 64'(obs_cout), 64'd1);

    run_one32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "ones");
    check("ones_sum",  64'(obs_sum),  64'hFFFFFFFF);
    check("ones_cout", 64'(obs_cout), 64'd1);

    run_one32(32'h00FF00FF, 32'h00010001, 1'b0, "chain");
    check("chain_sum",  64'(obs_sum),  64'h01000100);
    check("chain_cout", 64'(obs_cout), 64'd0);

`ifdef PIPE_RCA_OVF_EN
    run_one32(32'h7FFFFFFF, 32'h00000001, 1'b0, "ovf_pos");
    check("ovf_pos_sum",  64'(obs_sum),  64'h80000000);
    check("ovf_pos_ovf",  64'(obs_ovf),  64'd1);
    check("ovf_pos_cout", 64'(obs_cout), 64'd0);
    run_one32(32'hFFFFFFFF, 32'h00000001, 1'b0, "ovf_neg");
    check("ovf_neg_ovf",  64'(obs_ovf),  64'd0);
`endif

    // Ten back-to-back operations with the consumer stalled in cycles 3..8.
    sent = 0; recv = 0; fell_at = -1; held_valid = 1'b0; held_sum = '0;
    for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
      @(negedge clk);
      bus32.out_ready = !(cyc >= 3 && cyc <= 8);
      bus32.in_valid  = (sent < 10);
      bus32.a   = (sent < 10) ? a_t[sent] : 32'h0;
      bus32.b   = (sent < 10) ? b_t[sent] : 32'h0;
      bus32.cin = (sent < 10) ? c_t[sent] : 1'b0;
      #1;
      if (held_valid) begin
        check("stall_valid", 64'(bus32.out_valid), 64'd1);
        check("stall_sum",   64'(bus32.sum),       64'(held_sum));
      end
      if (!bus32.in_ready && fell_at < 0) fell_at = sent - recv;
      acc  = bus32.in_valid && bus32.in_ready;
      xfer = bus32.out_valid && bus32.out_ready;
      if (xfer) begin
        e = {1'b0, a_t[recv]} + {1'b0, b_t[recv]} + 33'(c_t[recv]);
        check($sformatf("burst_sum%0d", recv),  64'(bus32.sum),  64'(e[31:0]));
        check($sformatf("burst_cout%0d", recv), 64'(bus32.cout), 64'(e[32]));
        recv++;
      end
      held_valid = bus32.out_valid && !bus32.out_ready;
      held_sum   = bus32.sum;
      @(posedge clk);
      if (acc) sent++;
    end
    bus32.in_valid = 1'b0;
    check("burst_inflight_at_stall", 64'(fell_at), 64'd4);
    check("burst_sent", 64'(sent), 64'd10);
    check("burst_recv", 64'(recv), 64'd10);

    // Reset with three operations in flight and the head result waiting.
    @(negedge clk);
    bus32.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus32.a = a_t[i]; bus32.b = b_t[i]; bus32.cin = c_t[i]; bus32.in_valid = 1'b1;
      @(negedge clk);
    end
    bus32.in_valid = 1'b0;
    lat = 0;
    while (!bus32.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("flight_out_valid", 64'(bus32.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(bus32.out_valid), 64'd0);
    check("midrst_sum",       64'(bus32.sum),       64'd0);
    check("midrst_cout",      64'(bus32.cout),      64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("postrst_in_ready", 64'(bus32.in_ready), 64'd1);
    bus32.out_ready = 1'b1;
    saw_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus32.out_valid) saw_valid++;
    end
    check("postrst_no_stale", 64'(saw_valid), 64'd0);

    run_one16(16'hAAAA, 16'h5555, 1'b0, "w16_alt");
    check("w16_alt_sum",  64'(obs_sum),  64'hFFFF);
    check("w16_alt_cout", 64'(obs_cout), 64'd0);
    run_one16(16'h0001, 16'h0002, 1'b1, "w16_small");
    check("w16_small_sum",  64'(obs_sum),  64'h0004);
    check("w16_small_cout", 64'(obs_cout), 64'd0);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_rca.md
PIPE_RCA -- requirements
Module: pipe_rca

Interface
REQ-001 Parameter WIDTH, default 32, operand and sum width in bits.
REQ-002 Parameter CHUNK, default 8, bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK; NSTG = WIDTH/CHUNK.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  operands a, b, cin present.
REQ-007 in_ready  output  1  pipeline accepts an operation this cycle.
REQ-008 a, b  input  WIDTH  unsigned operands.
REQ-009 cin  input  1  carry-in.
REQ-010 out_valid  output  1  sum/cout hold a completed result.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
REQ-013 cout  output  1  bit WIDTH of a + b + cin.

Function
REQ-014 Operation accepted on a rising edge with in_valid && in_ready; result transferred on a rising edge with out_valid && out_ready.
REQ-015 Stage k (0..NSTG-1) adds chunk k of a and b plus the registered carry from stage k-1 (cin for stage 0), registering the partial sum, its carry-out and the not-yet-added upper operand chunks.
REQ-016 Latency exactly NSTG cycles from acceptance to out_valid when out_ready is held high; throughput one operation per cycle.
REQ-017 Each stage has a valid bit; stage k loads when it is empty or stage k+1 (or the consumer, for the last stage) accepts this cycle; bubbles collapse.
REQ-018 in_ready = stage 0 empty or stage 0 advancing this cycle; combinational from out_ready through the ready chain, no registered skid.
REQ-019 With out_valid high and out_ready low, sum, cout and out_valid SHALL remain stable until transfer.
REQ-020 Results emerge in acceptance order; none dropped or duplicated, including under simultaneous accept and transfer with a full pipeline.
REQ-021 Carry SHALL propagate across every chunk boundary; all-ones + 1 wraps sum to 0 with cout = 1.
REQ-022 Operands and cin sampled only on acceptance; changes while in_ready low are ignored.

Reset
REQ-023 rst high clears all stage valid bits, out_valid = 0, sum = 0, cout = 0 (and ovf = 0 when compiled in) asynchronously.
REQ-024 Reset mid-operation discards all in-flight operations; in_ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-025 Macro PIPE_RCA_OVF_EN: when defined, an output ovf (1 bit) SHALL equal the two's-complement signed overflow of a + b + cin, pipelined and held with sum.
REQ-026 Without PIPE_RCA_OVF_EN, no ovf port and no overflow logic exist; all other behaviour is identical.

Structure
REQ-027 Shared package pipe_rca_pkg holds default WIDTH/CHUNK constants and the per-stage record typedef (valid, partial sum, carry, remaining operand bits).
REQ-028 Sub-module rca_chunk: combinational CHUNK-bit ripple-carry adder (a, b, cin -> s, co), instantiated once per stage.
REQ-029 Elaboration-time check fails if WIDTH mod CHUNK != 0 or CHUNK < 1.

Verification
REQ-030 Defaults, out_ready=1: 0 + 0 + 0 -> sum 0x00000000, cout 0, out_valid exactly 4 cycles after acceptance.
REQ-031 0xFFFFFFFF + 0x00000001 + 0 -> sum 0x00000000, cout 1; 0xFFFFFFFF + 0xFFFFFFFF + 1 -> sum 0xFFFFFFFF, cout 1.
REQ-032 Ten back-to-back operations, out_ready low for cycles 3-8: in_ready falls after 4 held operations, all ten results emerge in order and equal a+b+cin, sum stable while stalled.
REQ-033 rst pulsed with 3 operations in flight -> out_valid 0 immediately, no stale result afterward, in_ready 1 after release.
REQ-034 WIDTH=16, CHUNK=4: 0xAAAA + 0x5555 + 0 -> 0xFFFF, cout 0; 0x0001 + 0x0002 + 1 -> 0x0004 after 4 cycles.
REQ-035 PIPE_RCA_OVF_EN defined: 0x7FFFFFFF + 0x00000001 + 0 -> sum 0x80000000, ovf 1, cout 0; 0xFFFFFFFF + 1 -> ovf 0.
